// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Purpose: parametrised oversampled UART receiver with line synchroniser, false-start rejection and error flags.
// Latency: out_valid rises on the s_tick edge that samples the last stop bit (line delay SYNC_STAGES clk).
// Backpressure: none on the line; an unacknowledged word is overwritten and flagged by sticky overrun.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 out_ack,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 receiving
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  // Index of the final stop bit (stop_q is 0 for the first, 1 for the second)
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   par_bit_q, par_bit_d;
  logic                   fe_q, fe_d;
  logic                   stop0_q, stop0_d;
  logic                   commit;
  logic                   brk;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // Bring the asynchronous line into the clock domain; idles high out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Frame state and per-frame accumulators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      fe_q      <= 1'b0;
      stop0_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      par_bit_q <= par_bit_d;
      fe_q      <= fe_d;
      stop0_q   <= stop0_d;
    end
  end

  // Next-state: everything advances only on oversample ticks; sampling at bit mid-points
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    par_bit_d = par_bit_q;
    fe_d      = fe_q;
    stop0_d   = stop0_q;
    commit    = 1'b0;
    if (s_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID) begin
            if (!rx_s) begin
              // Start bit confirmed at its mid-point: clear last frame's accumulators
              state_d   = S_DATA;
              tick_d    = '0;
              bit_d     = '0;
              stop_d    = 1'b0;
              par_err_d = 1'b0;
              par_bit_d = 1'b0;
              fe_d      = 1'b0;
            end else begin
              // Glitch shorter than half a bit: drop silently
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            // LSB arrives first, so shifting right leaves it at bit 0 after the last bit
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            par_bit_d = rx_s;
            par_err_d = (rx_s != ((PARITY == 2) ? ^shift_q : ~^shift_q));
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            fe_d   = fe_q | ~rx_s;
            if (stop_q == 1'b0) begin
              stop0_d = rx_s;
            end
            if (stop_q == STOP_LAST) begin
              // No stop extension: the line is watched for a new start right away
              commit  = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign brk       = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !stop0_d;
  assign receiving = (state_q != S_IDLE) && !commit;

  // Output word and flags: loaded together on commit, valid cleared by ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      out_data   <= shift_q;
      out_valid  <= 1'b1;
      parity_err <= par_err_q;
      frame_err  <= fe_d;
      break_det  <= brk;
      if (out_valid && !out_ack) begin
        overrun <= 1'b1;
      end
    end else if (out_ack && out_valid) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
